usb_fs_in_ep_streamer: RTL and testbench
========================================

USB_FS_IN_EP_STREAMER -- requirements
Module: usb_fs_in_ep_streamer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, meaning maximum IN packet payload bytes (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 128, meaning byte FIFO depth (power of two, at least MAX_PKT).
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 4096, meaning idle cycles before a short packet is forced (at least 1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic; all registers update on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port src_valid, input, 1, meaning a user byte is offered.
REQ-007 SHALL have port src_ready, output, 1, meaning the FIFO can accept a byte; the byte transfers when src_valid && src_ready.
REQ-008 SHALL have port src_data, input, 8, meaning the user byte.
REQ-009 SHALL have port src_flush, input, 1, meaning a one-cycle request to send buffered data now.
REQ-010 SHALL have port src_stall, input, 1, meaning the endpoint halt request.
REQ-011 SHALL have port in_ep_req, output, 1, meaning an arbitration request to the protocol engine.
REQ-012 SHALL have port in_ep_grant, input, 1, meaning arbitration granted.
REQ-013 SHALL have port in_ep_data_free, input, 1, meaning the engine's endpoint buffer can accept data.
REQ-014 SHALL have port in_ep_data_put, output, 1, meaning in_ep_data is written this cycle.
REQ-015 SHALL have port in_ep_data, output, 8, meaning the packet byte.
REQ-016 SHALL have port in_ep_data_done, output, 1, meaning a one-cycle pulse that closes the packet.
REQ-017 SHALL have port in_ep_stall, output, 1, meaning the endpoint is halted.
REQ-018 SHALL have port in_ep_acked, input, 1, meaning the host ACKed a packet.
REQ-019 SHALL have port pkt_sent_count, output, 16, meaning the number of ACKed packets, wrapping at 0xFFFF to 0.

Function
REQ-020 SHALL implement a FIFO_DEPTH byte FIFO with an occupancy count; src_ready = (count != FIFO_DEPTH).
REQ-021 SHALL drive in_ep_data combinationally from the FIFO head; each in_ep_data_put pops exactly one byte in that cycle.
REQ-022 SHALL implement states IDLE, REQ, XFER, DONE.
REQ-023 SHALL go from IDLE to REQ when count >= MAX_PKT, or when a flush is pending and count > 0, or when the idle timer expires with count > 0.
REQ-024 SHALL assert in_ep_req in REQ, XFER and DONE, deassert it in IDLE, and go from REQ to XFER in the cycle after in_ep_grant is sampled high.
REQ-025 SHALL, in XFER, set in_ep_data_put = in_ep_grant && in_ep_data_free && count > 0 && bytes_in_pkt < MAX_PKT.
REQ-026 SHALL leave XFER for DONE when bytes_in_pkt reaches MAX_PKT or the FIFO becomes empty.
REQ-027 SHALL pulse in_ep_data_done for exactly one cycle in DONE, then return to IDLE, clearing bytes_in_pkt.
REQ-028 SHALL stall XFER with no put while in_ep_data_free is low; no byte is lost or duplicated.
REQ-029 SHALL latch src_flush into a pending flag, and clear that flag when in_ep_data_done is issued for a packet shorter than MAX_PKT or for a ZLP.
REQ-030 SHALL reload the idle timer on each accepted src byte and on each in_ep_data_done, and decrement it only in IDLE with count > 0; expiry equals 0.
REQ-031 SHALL give a push precedence at FIFO full: when a push and a pop occur in the same cycle, count is unchanged.
REQ-032 SHALL register src_stall into in_ep_stall (1-cycle latency); while in_ep_stall = 1, the IDLE-to-REQ transition SHALL be blocked, while an in-progress packet completes normally.
REQ-033 SHALL increment pkt_sent_count by 1 on each cycle in which in_ep_acked = 1.
REQ-034 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-035 SHALL, on reset, set state to IDLE, empty the FIFO, set src_ready=1, and set in_ep_req, in_ep_data_put, in_ep_data_done and in_ep_stall to 0.
REQ-036 SHALL, on reset, set pkt_sent_count=0, clear the pending flush and ZLP flags, and load the idle timer with FLUSH_TIMEOUT.
REQ-037 SHALL, on reset mid-packet, discard the partial packet with no in_ep_data_done issued.

Configuration
REQ-038 SHALL use the macro USB_IN_EP_ZLP_EN to select zero-length packet (ZLP) behaviour.
REQ-039 SHALL, when USB_IN_EP_ZLP_EN is defined, set a ZLP flag when a flush-terminated transfer ends with a packet of exactly MAX_PKT bytes and the FIFO is empty.
REQ-040 SHALL, when the ZLP flag is set, perform IDLE, REQ, XFER (zero puts), DONE, pulsing in_ep_data_done with zero bytes, then clear the flag.
REQ-041 SHALL, when USB_IN_EP_ZLP_EN is undefined, never generate a ZLP and have no ZLP flag logic.

Verification
REQ-042 SHALL cover: MAX_PKT=64, push 64 bytes 0x00..0x3F, grant and data_free held 1 -> 64 consecutive puts with data 0x00..0x3F, then a single done pulse.
REQ-043 SHALL cover: push 5 bytes, then pulse src_flush -> one packet of 5 bytes and done; FIFO empty; flush flag clear.
REQ-044 SHALL cover: push 3 bytes and wait FLUSH_TIMEOUT=16 idle cycles -> req asserts 1 cycle after expiry; 3-byte packet sent.
REQ-045 SHALL cover: drop data_free for 10 cycles mid-packet after 20 bytes -> no puts during the gap; the remaining 44 bytes are in order; total exactly 64.
REQ-046 SHALL cover, with USB_IN_EP_ZLP_EN: push 64 bytes and flush -> a 64-byte packet, then a zero-byte packet (done with no puts); without the macro, only the 64-byte packet.
REQ-047 SHALL cover: fill FIFO to 128, assert reset during XFER, pulse in_ep_acked 3 times afterwards -> src_ready=1, count 0, no done, pkt_sent_count=3.

Source files
------------

// File: rtl/usb_fs_in_ep_streamer.sv
// USB full-speed IN endpoint streamer: buffers user bytes and feeds them to the protocol engine as MAX_PKT-byte IN packets.
// Optional feature macro: USB_IN_EP_ZLP_EN adds a zero-length packet after a flushed transfer that ends on a full packet.

module usb_fs_in_ep_streamer #(
   parameter int MAX_PKT       = 64,
   parameter int FIFO_DEPTH    = 128,
   parameter int FLUSH_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        src_valid,
   output logic        src_ready,
   input  logic [7:0]  src_data,
   input  logic        src_flush,
   input  logic        src_stall,
   output logic        in_ep_req,
   input  logic        in_ep_grant,
   input  logic        in_ep_data_free,
   output logic        in_ep_data_put,
   output logic [7:0]  in_ep_data,
   output logic        in_ep_data_done,
   output logic        in_ep_stall,
   input  logic        in_ep_acked,
   output logic [15:0] pkt_sent_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(MAX_PKT + 1);
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

   localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] PKT_COUNT   = CW'(MAX_PKT);
   localparam logic [BW-1:0] PKT_BYTES   = BW'(MAX_PKT);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(FLUSH_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [BW-1:0]   r_bytes;
   logic [TW-1:0]   r_timer;
   logic            r_flush_pend;
   logic            r_stall;
   logic [15:0]     r_pkt_cnt;

   logic            w_push;
   logic            w_put;
   logic            w_done;
   logic            w_req;
   logic            w_start;
   logic            w_zlp;
   logic            w_fifo_empty;
   logic            w_pkt_full;

   assign src_ready      = (r_count != FIFO_FULL);
   assign w_push         = src_valid && src_ready;
   assign w_fifo_empty   = (r_count == '0);
   assign w_pkt_full     = (r_bytes == PKT_BYTES);
   assign in_ep_data     = r_mem[r_rd_ptr];
   assign in_ep_data_put = w_put;
   assign in_ep_data_done = w_done;
   assign in_ep_req      = w_req;
   assign in_ep_stall    = r_stall;
   assign pkt_sent_count = r_pkt_cnt;

   // NOTE: the storage array has no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= src_data;
   end

   // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_put)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_put})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_start = !r_stall &&
                    ((r_count >= PKT_COUNT) ||
                     (r_flush_pend && !w_fifo_empty) ||
                     ((r_timer == '0) && !w_fifo_empty) ||
                     w_zlp);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      w_req  = 1'b1;
      w_put  = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req = 1'b0;
            if (w_start) w_next = S_REQ;
         end
         S_REQ: begin
            if (in_ep_grant) w_next = S_XFER;
         end
         S_XFER: begin
            if (w_zlp || w_pkt_full || w_fifo_empty) w_next = S_DONE;
            else w_put = in_ep_grant && in_ep_data_free && !reset;
         end
         S_DONE: begin
            w_done = !reset;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset)                  r_bytes <= '0;
      else if (r_state == S_DONE) r_bytes <= '0;
      else if (w_put)             r_bytes <= r_bytes + 1'b1;
   end

   // A new flush request wins over clearing on a short packet in the same cycle.
   always_ff @(posedge clk) begin
      if (reset)                             r_flush_pend <= 1'b0;
      else if (src_flush)                    r_flush_pend <= 1'b1;
      else if (w_done && (r_bytes < PKT_BYTES)) r_flush_pend <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)                   r_timer <= TIMER_RELOAD;
      else if (w_push || w_done)   r_timer <= TIMER_RELOAD;
      else if ((r_state == S_IDLE) && !w_fifo_empty && (r_timer != '0))
                                   r_timer <= r_timer - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall   <= 1'b0;
         r_pkt_cnt <= '0;
      end else begin
         r_stall <= src_stall;
         if (in_ep_acked) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
   end

`ifdef USB_IN_EP_ZLP_EN
   logic r_zlp;

   // Armed by a full packet that drained a flushed FIFO; the next packet then carries no data.
   always_ff @(posedge clk) begin
      if (reset)       r_zlp <= 1'b0;
      else if (w_done) r_zlp <= !r_zlp && r_flush_pend && w_pkt_full && w_fifo_empty;
   end

   assign w_zlp = r_zlp;
`else
   assign w_zlp = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fs_in_ep_streamer.sv
// Self-checking bench for usb_fs_in_ep_streamer: scoreboard of pushed bytes, table of packet scenarios,
// plus hand-written timeout, back-pressure, stall, ZLP and mid-packet reset sequences.

module tb_usb_fs_in_ep_streamer;

   localparam int MAX_PKT       = 64;
   localparam int FIFO_DEPTH    = 128;
   localparam int FLUSH_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        src_valid;
   logic        src_ready;
   logic [7:0]  src_data;
   logic        src_flush;
   logic        src_stall;
   logic        in_ep_req;
   logic        in_ep_grant;
   logic        in_ep_data_free;
   logic        in_ep_data_put;
   logic [7:0]  in_ep_data;
   logic        in_ep_data_done;
   logic        in_ep_stall;
   logic        in_ep_acked;
   logic [15:0] pkt_sent_count;

   usb_fs_in_ep_streamer #(
      .MAX_PKT       (MAX_PKT),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .src_data        (src_data),
      .src_flush       (src_flush),
      .src_stall       (src_stall),
      .in_ep_req       (in_ep_req),
      .in_ep_grant     (in_ep_grant),
      .in_ep_data_free (in_ep_data_free),
      .in_ep_data_put  (in_ep_data_put),
      .in_ep_data      (in_ep_data),
      .in_ep_data_done (in_ep_data_done),
      .in_ep_stall     (in_ep_stall),
      .in_ep_acked     (in_ep_acked),
      .pkt_sent_count  (pkt_sent_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Scoreboard: bytes accepted by the FIFO, in order; popped on every put.
   logic [7:0] sb [$];
   int         done_lens [$];
   int         spans [$];
   int         pkt_puts   = 0;
   int         done_count = 0;
   int         cyc        = 0;
   int         first_cyc  = 0;
   int         last_cyc   = 0;

   always @(negedge clk) begin
      logic [7:0] exp_byte;
      cyc++;
      if (in_ep_data_done) begin
         done_lens.push_back(pkt_puts);
         spans.push_back((pkt_puts == 0) ? -1 : (last_cyc - first_cyc));
         done_count++;
         pkt_puts = 0;
      end
      if (reset) begin
         sb.delete();
         pkt_puts = 0;
      end else begin
         if (in_ep_data_put) begin
            if (sb.size() == 0) begin
               check("put_with_empty_scoreboard", int'(in_ep_data_put), 0);
            end else begin
               exp_byte = sb.pop_front();
               check("put_data", int'(in_ep_data), int'(exp_byte));
            end
            if (pkt_puts == 0) first_cyc = cyc;
            last_cyc = cyc;
            pkt_puts++;
         end
         if (src_valid && src_ready) sb.push_back(src_data);
      end
   end

   logic [7:0] next_byte = 8'h00;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_bytes(input int n);
      logic rdy;
      int   w;
      for (int i = 0; i < n; i++) begin
         src_valid = 1'b1;
         src_data  = next_byte;
         w = 0;
         do begin
            @(negedge clk);
            rdy = src_ready;
            @(posedge clk);
            #1;
            w++;
         end while (!rdy && w < 2000);
         if (!rdy) check("push_accept_timeout", int'(src_ready), 1);
         next_byte = next_byte + 8'h01;
      end
      src_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      src_flush = 1'b1;
      tick(1);
      src_flush = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int w;
      w = 0;
      while (done_count < target && w < budget) begin
         tick(1);
         w++;
      end
      check(name, done_count, target);
   endtask

   typedef struct {
      int n_push;
      bit flush;
      int exp_pkts;
      int exp_len0;
      int exp_len1;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;

      vecs[0] = '{n_push: 64, flush: 1'b0, exp_pkts: 1, exp_len0: 64, exp_len1: 0};
      vecs[1] = '{n_push: 5,  flush: 1'b1, exp_pkts: 1, exp_len0: 5,  exp_len1: 0};
      vecs[2] = '{n_push: 1,  flush: 1'b1, exp_pkts: 1, exp_len0: 1,  exp_len1: 0};
      vecs[3] = '{n_push: 70, flush: 1'b1, exp_pkts: 2, exp_len0: 64, exp_len1: 6};

      reset           = 1'b1;
      src_valid       = 1'b0;
      src_data        = 8'h00;
      src_flush       = 1'b0;
      src_stall       = 1'b0;
      in_ep_grant     = 1'b1;
      in_ep_data_free = 1'b1;
      in_ep_acked     = 1'b0;
      tick(3);

      check("rst_src_ready", int'(src_ready), 1);
      check("rst_req", int'(in_ep_req), 0);
      check("rst_put", int'(in_ep_data_put), 0);
      check("rst_done", int'(in_ep_data_done), 0);
      check("rst_stall", int'(in_ep_stall), 0);
      check("rst_pkt_sent", int'(pkt_sent_count), 0);
      reset = 1'b0;
      tick(2);

      // Table of packet scenarios: full packet, flushed short packets, full plus flushed remainder.
      for (int i = 0; i < 4; i++) begin
         base = done_count;
         push_bytes(vecs[i].n_push);
         if (vecs[i].flush) pulse_flush();
         wait_done(base + vecs[i].exp_pkts, 600, "vec_done_seen");
         tick(5);
         check("vec_no_extra_pkt", done_count, base + vecs[i].exp_pkts);
         check("vec_len0", done_lens[base], vecs[i].exp_len0);
         check("vec_consecutive", spans[base], vecs[i].exp_len0 - 1);
         if (vecs[i].exp_pkts > 1) check("vec_len1", done_lens[base + 1], vecs[i].exp_len1);
         check("vec_sb_empty", sb.size(), 0);
         check("vec_fifo_empty", int'(dut.r_count), 0);
         check("vec_flush_clear", int'(dut.r_flush_pend), 0);
      end

      // Idle timeout forces a short packet; req rises one cycle after the timer hits zero.
      base = done_count;
      push_bytes(3);
      k = 0;
      while (!in_ep_req && k < 100) begin
         tick(1);
         k++;
      end
      check("timeout_req_latency", k, FLUSH_TIMEOUT + 1);
      wait_done(base + 1, 200, "timeout_done_seen");
      check("timeout_len", done_lens[base], 3);

      // Back-pressure: data_free low for 10 cycles after 20 bytes.
      base = done_count;
      push_bytes(64);
      k = 0;
      while (pkt_puts < 20 && k < 500) begin
         tick(1);
         k++;
      end
      in_ep_data_free = 1'b0;
      check("gap_start_puts", pkt_puts, 20);
      tick(10);
      check("gap_no_puts", pkt_puts, 20);
      in_ep_data_free = 1'b1;
      wait_done(base + 1, 300, "gap_done_seen");
      check("gap_len", done_lens[base], 64);
      check("gap_sb_empty", sb.size(), 0);

      // Stall: one-cycle latency, blocks new packets, lets an in-progress one finish.
      src_stall = 1'b1;
      check("stall_pre_edge", int'(in_ep_stall), 0);
      tick(1);
      check("stall_latency", int'(in_ep_stall), 1);
      base = done_count;
      push_bytes(64);
      tick(20);
      check("stall_blocks_req", int'(in_ep_req), 0);
      check("stall_no_done", done_count, base);
      src_stall = 1'b0;
      k = 0;
      while (!in_ep_req && k < 20) begin
         tick(1);
         k++;
      end
      check("stall_release_req", int'(in_ep_req), 1);
      src_stall = 1'b1;
      wait_done(base + 1, 300, "stall_pkt_completes");
      check("stall_len", done_lens[base], 64);
      src_stall = 1'b0;
      tick(3);

      // Flushed transfer ending on a full packet.
      base = done_count;
      push_bytes(64);
      pulse_flush();
`ifdef USB_IN_EP_ZLP_EN
      wait_done(base + 2, 400, "zlp_done_seen");
      tick(10);
      check("zlp_pkt_count", done_count, base + 2);
      check("zlp_len_full", done_lens[base], 64);
      check("zlp_len_zero", done_lens[base + 1], 0);
      check("zlp_flush_clear", int'(dut.r_flush_pend), 0);
`else
      wait_done(base + 1, 400, "nozlp_done_seen");
      tick(40);
      check("nozlp_pkt_count", done_count, base + 1);
      check("nozlp_len_full", done_lens[base], 64);
`endif

      // Fill to capacity with no grant, then reset in the middle of a packet.
      in_ep_grant = 1'b0;
      push_bytes(FIFO_DEPTH);
      check("full_src_ready", int'(src_ready), 0);
      check("full_count", int'(dut.r_count), FIFO_DEPTH);
      check("full_req_waiting", int'(in_ep_req), 1);
      in_ep_grant = 1'b1;
      k = 0;
      while (pkt_puts < 10 && k < 100) begin
         tick(1);
         k++;
      end
      check("xfer_active", int'(in_ep_data_put), 1);
      base = done_count;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      check("midrst_src_ready", int'(src_ready), 1);
      check("midrst_count", int'(dut.r_count), 0);
      check("midrst_req", int'(in_ep_req), 0);
      check("midrst_pkt_sent", int'(pkt_sent_count), 0);
      tick(30);
      check("midrst_no_done", done_count, base);
      check("midrst_still_idle", int'(in_ep_req), 0);
      for (int i = 0; i < 3; i++) begin
         in_ep_acked = 1'b1;
         tick(1);
         in_ep_acked = 1'b0;
         tick(1);
      end
      check("acked_count", int'(pkt_sent_count), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
